ipd_ctrl_param: RTL

// - Parametrised I-PD servo controller: Yk = I(k) - Kp*Pot - Kd*(Pot - Pot(k-1)), I(k) = I(k-1) + Ki*(Ref - Pot).
// - Gains are run-time ports. Outputs saturate to the output width.
// - Start/done handshake, overrun detection and integrator clear.
// - Sits between the ADC sample path (Pot, Ref, Rx_En) and the PWM/servo driver (Yk).

---
 rtl/ipd_ctrl_param_if.sv | 29 ++
 rtl/ipd_ctrl_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ipd_ctrl_param_if.sv
// Sample/gain/handshake bundle between the ADC sample path and the I-PD controller.
interface ipd_ctrl_param_if #(
    parameter int W  = 13,
    parameter int KW = 13,
    parameter int OW = 2 * W
);
    logic                 Rx_En;
    logic signed [W-1:0]  Pot;
    logic signed [W-1:0]  Ref;
    logic signed [KW-1:0] Kp;
    logic signed [KW-1:0] Ki;
    logic signed [KW-1:0] Kd;
    logic                 Clr_I;
    logic signed [OW-1:0] Yk;
    logic                 Done;
    logic                 Busy;
    logic                 Sat;
    logic                 Overrun;

    modport master (
        output Rx_En, Pot, Ref, Kp, Ki, Kd, Clr_I,
        input  Yk, Done, Busy, Sat, Overrun
    );

    modport slave (
        input  Rx_En, Pot, Ref, Kp, Ki, Kd, Clr_I,
        output Yk, Done, Busy, Sat, Overrun
    );
endinterface

// File: rtl/ipd_ctrl_param.sv
// I-PD servo controller: Yk = I(k) - Kp*Pot - Kd*(Pot - Pot(k-1)), I(k) = I(k-1) + Ki*(Ref - Pot).
// Define IPD_ANTIWINDUP_EN to freeze the integrator whenever the output would clip.
module ipd_ctrl_param #(
    parameter int W  = 13,
    parameter int KW = 13,
    parameter int OW = 2 * W
) (
    input  logic              Clk_G,
    input  logic              Rst_G,
    ipd_ctrl_param_if.slave   bus
);
    localparam int PW = W + KW + 1;
    // Sum width covers the integrator plus three full products, so nothing wraps before clamping.
    localparam int SW = ((OW > PW) ? OW : PW) + 2;
    localparam logic signed [SW-1:0] SAT_HI = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LATCH, MUL, SUM, OUT} state_t;

    state_t state, state_nxt;
    logic   accept;

    logic signed [W-1:0]  pot_p0, ref_p0, pot_prev;
    logic signed [KW-1:0] kp_p0, ki_p0, kd_p0;
    logic signed [W:0]    ek_p1, dp_p1;
    logic signed [PW-1:0] p_p2, d_p2, mi_p2;
    logic signed [SW-1:0] inew_p2, yraw_p2, yraw_p3;
    logic signed [OW-1:0] integ, yk;
    logic                 done, busy, sat, overrun, hold_i;

    function automatic logic is_sat(input logic signed [SW-1:0] x);
        return (x > SAT_HI) || (x < SAT_LO);
    endfunction

    function automatic logic signed [OW-1:0] clamp(input logic signed [SW-1:0] x);
        if (x > SAT_HI)
            return SAT_HI[OW-1:0];
        else if (x < SAT_LO)
            return SAT_LO[OW-1:0];
        else
            return x[OW-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.Rx_En;
                if (bus.Rx_En)
                    state_nxt = LATCH;
            end
            LATCH:   state_nxt = MUL;
            MUL:     state_nxt = SUM;
            SUM:     state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inew_p2 = SW'(integ) + SW'(mi_p2);
        yraw_p2 = inew_p2 - SW'(p_p2) - SW'(d_p2);
    end

`ifdef IPD_ANTIWINDUP_EN
    assign hold_i = is_sat(yraw_p2);
`else
    assign hold_i = 1'b0;
`endif

    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            overrun  <= 1'b0;
            yk       <= '0;
            integ    <= '0;
            pot_prev <= '0;
        end else begin
            state   <= state_nxt;
            done    <= 1'b0;
            overrun <= bus.Rx_En && (state != IDLE);
            if (accept)
                busy <= 1'b1;
            else if (state == OUT)
                busy <= 1'b0;
            if (state == SUM && !hold_i)
                integ <= clamp(inew_p2);
            if (state == OUT) begin
                yk       <= clamp(yraw_p3);
                sat      <= is_sat(yraw_p3);
                done     <= 1'b1;
                pot_prev <= pot_p0;
            end
            // Clear wins over any coincident integrator or Pot(k-1) update.
            if (bus.Clr_I) begin
                integ    <= '0;
                pot_prev <= '0;
            end
        end
    end

    always_ff @(posedge Clk_G) begin
        // p0: sample and gains captured on accept
        if (accept) begin
            pot_p0 <= bus.Pot;
            ref_p0 <= bus.Ref;
            kp_p0  <= bus.Kp;
            ki_p0  <= bus.Ki;
            kd_p0  <= bus.Kd;
        end
        // p1: error and position delta
        if (state == LATCH) begin
            ek_p1 <= (W+1)'(ref_p0) - (W+1)'(pot_p0);
            dp_p1 <= (W+1)'(pot_p0) - (W+1)'(pot_prev);
        end
        // p2: full-precision products
        if (state == MUL) begin
            p_p2  <= PW'(kp_p0) * PW'(pot_p0);
            d_p2  <= PW'(kd_p0) * PW'(dp_p1);
            mi_p2 <= PW'(ki_p0) * PW'(ek_p1);
        end
        // p3: unclamped output sum
        if (state == SUM)
            yraw_p3 <= yraw_p2;
    end

    assign bus.Yk      = yk;
    assign bus.Done    = done;
    assign bus.Busy    = busy;
    assign bus.Sat     = sat;
    assign bus.Overrun = overrun;
endmodule
